// File: rtl/dbus_dma_master_if.sv
// dBus initiator/target bundle for the word-copy DMA.
// Command channel is valid/ready; the response is a single-cycle pulse.
interface dbus_dma_master_if;
  logic        m_cmd_valid;
  logic        m_cmd_ready;
  logic        m_cmd_wr;
  logic [31:0] m_cmd_address;
  logic [31:0] m_cmd_data;
  logic [1:0]  m_cmd_size;
  logic        m_rsp_ready;
  logic [31:0] m_rsp_data;
  logic        m_rsp_error;

  modport master (
    output m_cmd_valid,
    output m_cmd_wr,
    output m_cmd_address,
    output m_cmd_data,
    output m_cmd_size,
    input  m_cmd_ready,
    input  m_rsp_ready,
    input  m_rsp_data,
    input  m_rsp_error
  );

  modport slave (
    input  m_cmd_valid,
    input  m_cmd_wr,
    input  m_cmd_address,
    input  m_cmd_data,
    input  m_cmd_size,
    output m_cmd_ready,
    output m_rsp_ready,
    output m_rsp_data,
    output m_rsp_error
  );
endinterface

// File: rtl/dbus_dma_master.sv
// Word-copy DMA master on dBus, programmed via cs/oe/wstrb registers.
// Define DMA_FILL_EN to add the CTRL.FILL pattern-fill mode.
module dbus_dma_master #(
  parameter int LEN_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          addr,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  input  logic                cs,
  input  logic                oe,
  input  logic [3:0]          wstrb,
  dbus_dma_master_if.master   m,
  output logic                irq
);

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_WAIT,
    WR_CMD,
    WR_WAIT,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      src_q, dst_q;
  logic [31:0]      cur_src, cur_dst;
  logic [31:0]      buf_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic             ie_q, done_q, err_q;
  logic             fill_q, fill_go;

  logic busy, reg_wr, ctrl_wr;
  logic start, start_nil, start_go;
  logic rd_ok, wr_ok, rsp_bad;
  logic unused_oe;

  assign unused_oe = oe;

  function automatic logic [31:0] bm(
    input logic [31:0] o,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    for (int i = 0; i < 4; i++)
      if (s[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction

  assign busy      = (state_q != IDLE);
  assign reg_wr    = cs & (|wstrb);
  assign ctrl_wr   = reg_wr & (addr == 2'd3) & wstrb[0];
  assign start     = ctrl_wr & data_in[0] & ~busy;
  assign start_nil = start & (len_q == '0);
  assign start_go  = start & (len_q != '0);

  assign rd_ok = (state_q == RD_WAIT)
               & m.m_rsp_ready & ~m.m_rsp_error;
  assign wr_ok = (state_q == WR_WAIT)
               & m.m_rsp_ready & ~m.m_rsp_error;
  assign rsp_bad = ((state_q == RD_WAIT)
                 | (state_q == WR_WAIT))
                 & m.m_rsp_ready & m.m_rsp_error;

`ifdef DMA_FILL_EN
  // FILL written together with START must steer this start
  assign fill_go = ctrl_wr ? data_in[5] : fill_q;
`else
  assign fill_q  = 1'b0;
  assign fill_go = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    m.m_cmd_valid   = 1'b0;
    m.m_cmd_wr      = 1'b0;
    m.m_cmd_address = {cur_src[31:2], 2'b00};
    m.m_cmd_data    = buf_q;
    m.m_cmd_size    = 2'b10;
    unique case (state_q)
      IDLE: begin
        if (start_go)
          state_d = fill_go ? WR_CMD : RD_CMD;
      end
      RD_CMD: begin
        m.m_cmd_valid = 1'b1;
        if (m.m_cmd_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (m.m_rsp_ready)
          state_d = m.m_rsp_error ? IDLE : WR_CMD;
      end
      WR_CMD: begin
        m.m_cmd_valid   = 1'b1;
        m.m_cmd_wr      = 1'b1;
        m.m_cmd_address = cur_dst;
        if (m.m_cmd_ready) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (m.m_rsp_ready) begin
          if (m.m_rsp_error)
            state_d = IDLE;
          else if (cnt_q == LEN_W'(1))
            state_d = FIN;
          else
            state_d = fill_q ? WR_CMD : RD_CMD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cur_src <= '0;
      cur_dst <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMA_FILL_EN
      fill_q  <= 1'b0;
`endif
    end else begin
      if (reg_wr && !busy) begin
        unique case (1'b1)
          (addr == 2'd0): begin
`ifdef DMA_FILL_EN
            src_q <= bm(src_q, data_in, wstrb);
`else
            src_q <= bm(src_q, data_in, wstrb)
                   & ~32'h3;
`endif
          end
          (addr == 2'd1):
            dst_q <= bm(dst_q, data_in, wstrb)
                   & ~32'h3;
          (addr == 2'd2):
            len_q <= LEN_W'(bm(32'(len_q),
                                 data_in, wstrb));
          default: ;
        endcase
      end

      if (ctrl_wr) begin
        ie_q <= data_in[4];
        if (data_in[2]) done_q <= 1'b0;
        if (data_in[3]) err_q  <= 1'b0;
`ifdef DMA_FILL_EN
        if (!busy) fill_q <= data_in[5];
`endif
      end

      if (start) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end

      if (start_go) begin
        cur_src <= src_q;
        cur_dst <= dst_q;
        cnt_q   <= len_q;
        if (fill_go) buf_q <= src_q;
      end

      if (rd_ok) buf_q <= m.m_rsp_data;

      if (wr_ok) begin
        cur_src <= cur_src + 32'd4;
        cur_dst <= cur_dst + 32'd4;
        cnt_q   <= cnt_q - LEN_W'(1);
      end

      if (rsp_bad) err_q <= 1'b1;

      // completion beats a same-cycle W1C of DONE
      if (start_nil || rsp_bad || state_q == FIN)
        done_q <= 1'b1;
    end
  end

  always_comb begin
    data_out = '0;
    unique case (addr)
      2'd0: data_out = {src_q[31:2], 2'b00};
      2'd1: data_out = dst_q;
      2'd2: data_out[LEN_W-1:0] = len_q;
      2'd3: data_out[5:0] = {fill_q, ie_q, err_q,
                             done_q, busy, 1'b0};
      default: data_out = '0;
    endcase
  end

  assign irq = done_q & ie_q;

endmodule

// File: tb/tb_dbus_dma_master.sv
// Scoreboard bench for dbus_dma_master: randomized dBus target,
// expected command stream derived from SRC/DST/LEN arithmetic.
module tb_dbus_dma_master;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [31:0] data_in, data_out;
  logic        cs, oe;
  logic [3:0]  wstrb;
  logic        irq;

  dbus_dma_master_if bus ();

  dbus_dma_master #(.LEN_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .cs       (cs),
    .oe       (oe),
    .wstrb    (wstrb),
    .m        (bus.master),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  cmd_t exp_q[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  function automatic logic [31:0] pat(
    input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // target behaviour knobs
  int stall_max = 0, rdly_max = 0;
  int force_stall = 0;
  bit hold_wr = 0;
  int err_idx = -1, cmd_idx = 0;
  int wr_cnt = 0, rd_cnt = 0;

  bit          held = 0, pend = 0, perr;
  int          stall_left = 0, pdly = 0;
  logic [31:0] pdata, h_addr, h_data;
  logic        h_wr;

  task automatic accept();
    cmd_t e;
    chk("cmd_expected", 32'(exp_q.size() != 0), 32'd1);
    chk("cmd_size", 32'(bus.m_cmd_size), 32'd2);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("cmd_wr", 32'(bus.m_cmd_wr), 32'(e.wr));
      chk("cmd_addr", bus.m_cmd_address, e.a);
      if (e.wr) chk("cmd_data", bus.m_cmd_data, e.d);
    end
    pend  = 1;
    pdly  = $urandom_range(rdly_max);
    pdata = bus.m_cmd_wr ? $urandom
                         : pat(bus.m_cmd_address);
    perr  = (cmd_idx == err_idx);
    cmd_idx++;
    if (bus.m_cmd_wr) wr_cnt++;
    else              rd_cnt++;
  endtask

  always @(negedge clk) begin
    bus.m_rsp_ready = 1'b0;
    bus.m_rsp_error = 1'($urandom_range(1));
    bus.m_rsp_data  = $urandom;
    if (reset) begin
      pend = 0;
      held = 0;
      bus.m_cmd_ready = 1'b0;
    end else begin
      if (pend) begin
        if (pdly == 0) begin
          bus.m_rsp_ready = 1'b1;
          bus.m_rsp_data  = pdata;
          bus.m_rsp_error = perr;
          pend = 0;
        end else pdly--;
      end
      if (bus.m_cmd_valid) begin
        if (held) begin
          chk("hold_wr", 32'(bus.m_cmd_wr), 32'(h_wr));
          chk("hold_addr", bus.m_cmd_address, h_addr);
          chk("hold_data", bus.m_cmd_data, h_data);
        end else begin
          chk("one_outstanding", 32'(pend), 32'd0);
          stall_left = (force_stall > 0) ? force_stall
                     : $urandom_range(stall_max);
          force_stall = 0;
        end
        if ((hold_wr && bus.m_cmd_wr) || stall_left > 0) begin
          bus.m_cmd_ready = 1'b0;
          if (stall_left > 0) stall_left--;
          held   = 1;
          h_wr   = bus.m_cmd_wr;
          h_addr = bus.m_cmd_address;
          h_data = bus.m_cmd_data;
        end else begin
          bus.m_cmd_ready = 1'b1;
          held = 0;
          accept();
        end
      end else begin
        if (held) chk("hold_valid", 32'd0, 32'd1);
        held = 0;
        bus.m_cmd_ready = 1'($urandom_range(1));
      end
    end
  end

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    addr = a; data_in = d;
    cs = 1'b1; oe = 1'b0; wstrb = 4'hF;
    @(negedge clk);
    cs = 1'b0; wstrb = 4'h0;
  endtask

  task automatic rd(input logic [1:0] a,
                    output logic [31:0] d);
    addr = a; cs = 1'b1; oe = 1'b1; wstrb = 4'h0;
    #1;
    d = data_out;
    cs = 1'b0; oe = 1'b0;
  endtask

  // reference: R(src+4i), W(dst+4i, mem[src+4i]) per word,
  // stream cut after the erroring command
  task automatic expect_xfer(input logic [31:0] s,
                             input logic [31:0] d,
                             input int n, input bit fill,
                             input int e);
    cmd_t q[$];
    logic [31:0] sa, da;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      if (!fill)
        q.push_back('{1'b0, sa + 32'(4*i), 32'h0});
      q.push_back('{1'b1, da + 32'(4*i),
                    fill ? s : pat(sa + 32'(4*i))});
    end
    if (e >= 0)
      while (q.size() > e + 1) void'(q.pop_back());
    foreach (q[i]) exp_q.push_back(q[i]);
  endtask

  task automatic prog_start(input logic [31:0] s,
                            input logic [31:0] d,
                            input int n, input bit fill,
                            input int e);
    logic [31:0] v;
    cmd_idx = 0; err_idx = e;
    wr_cnt = 0; rd_cnt = 0;
    wr(2'd0, s); wr(2'd1, d); wr(2'd2, 32'(n));
    rd(2'd0, v); chk("src_rb", v, {s[31:2], 2'b00});
    rd(2'd1, v); chk("dst_rb", v, {d[31:2], 2'b00});
    rd(2'd2, v); chk("len_rb", v, 32'(n));
    expect_xfer(s, d, n, fill, e);
    wr(2'd3, {26'd0, fill, 5'b00001});
  endtask

  task automatic finish_xfer(output logic [31:0] ctrl,
                             output int cyc);
    logic [31:0] v;
    cyc = 1;
    forever begin
      rd(2'd3, v);
      if (v[2]) break;
      if (cyc > 3000) begin
        chk("done_in_time", 32'(cyc), 32'd3000);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    repeat (6) @(negedge clk);
    rd(2'd3, ctrl);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] v, s, d;
    int cyc, n, e;

    reset = 1'b1; cs = 1'b0; oe = 1'b0;
    wstrb = 4'h0; addr = 2'd0; data_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd(2'd0, v); chk("rst_src", v, 32'h0);
    rd(2'd1, v); chk("rst_dst", v, 32'h0);
    rd(2'd2, v); chk("rst_len", v, 32'h0);
    rd(2'd3, v); chk("rst_ctrl", v, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_valid", 32'(bus.m_cmd_valid), 32'd0);

    // zero-wait copy of 3 words
    prog_start(32'h100, 32'h200, 3, 1'b0, -1);
    finish_xfer(v, cyc);
    chk("t1_ctrl", v, 32'h4);
    chk("t1_cycles", 32'(cyc), 32'd14);
    chk("t1_reads", 32'(rd_cnt), 32'd3);
    chk("t1_writes", 32'(wr_cnt), 32'd3);
    wr(2'd3, 32'h4);

    // LEN=0 start with IE
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h11);
    rd(2'd3, v); chk("t2_ctrl", v, 32'h14);
    chk("t2_irq", 32'(irq), 32'd1);
    wr(2'd3, 32'h14);
    rd(2'd3, v); chk("t2_clr", v, 32'h10);
    chk("t2_irq_clr", 32'(irq), 32'd0);
    wr(2'd3, 32'h0);

    // 5-cycle stall on the first command
    force_stall = 5;
    prog_start(32'h400, 32'h500, 1, 1'b0, -1);
    finish_xfer(v, cyc);
    chk("t3_ctrl", v, 32'h4);
    wr(2'd3, 32'h4);

    // error on second read
    prog_start(32'h600, 32'h700, 4, 1'b0, 2);
    finish_xfer(v, cyc);
    chk("t4_ctrl", v, 32'hC);
    chk("t4_writes", 32'(wr_cnt), 32'd1);
    chk("t4_reads", 32'(rd_cnt), 32'd2);
    wr(2'd3, 32'hC);
    rd(2'd3, v); chk("t4_clr", v, 32'h0);

    // address wrap plus writes while busy
    force_stall = 8;
    prog_start(32'hFFFF_FFFC, 32'h3000, 2, 1'b0, -1);
    wr(2'd1, 32'h9990);
    wr(2'd2, 32'h7);
    wr(2'd3, 32'h1);
    rd(2'd3, v); chk("t5_busy", 32'(v[1]), 32'd1);
    rd(2'd1, v); chk("t5_dst_kept", v, 32'h3000);
    rd(2'd2, v); chk("t5_len_kept", v, 32'h2);
    finish_xfer(v, cyc);
    chk("t5_ctrl", v, 32'h4);
    wr(2'd3, 32'h4);

`ifdef DMA_FILL_EN
    prog_start(32'hDEAD_BEEF, 32'h800, 2, 1'b1, -1);
    finish_xfer(v, cyc);
    chk("fill_ctrl", v, 32'h24);
    chk("fill_reads", 32'(rd_cnt), 32'd0);
    chk("fill_writes", 32'(wr_cnt), 32'd2);
    wr(2'd3, 32'h4);
`else
    wr(2'd3, 32'h20);
    rd(2'd3, v); chk("nofill_b5", v, 32'h0);
`endif

    // randomized transfers
    stall_max = 3; rdly_max = 3;
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(6, 1);
      s = 32'h1000_0000 | ($urandom & 32'h000F_FFFF);
      d = 32'h2000_0000 | ($urandom & 32'h000F_FFFF);
      e = ($urandom_range(2) == 0)
        ? $urandom_range(2*n - 1) : -1;
      prog_start(s, d, n, 1'b0, e);
      finish_xfer(v, cyc);
      chk("rnd_ctrl", v, (e >= 0) ? 32'hC : 32'h4);
      wr(2'd3, 32'hC);
      rd(2'd3, v); chk("rnd_clr", v, 32'h0);
    end

    // reset while a write command is held
    stall_max = 0; rdly_max = 0;
    hold_wr = 1;
    prog_start(32'h900, 32'hA00, 2, 1'b0, -1);
    cyc = 0;
    while (!(bus.m_cmd_valid && bus.m_cmd_wr)
           && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t8_wr_seen", 32'(bus.m_cmd_wr), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t8_valid", 32'(bus.m_cmd_valid), 32'd0);
    rd(2'd3, v); chk("t8_ctrl", v, 32'h0);
    rd(2'd0, v); chk("t8_src", v, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    hold_wr = 0;
    exp_q.delete();
    repeat (10) @(negedge clk);
    chk("t8_idle", 32'(bus.m_cmd_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
